gpmc_burst_sram: RTL and testbench
==================================

// Module: gpmc_burst_sram
// PURPOSE
//  Synchronous GPMC slave on the multiplexed address/data bus backed by an internal DEPTH-word RAM.
//  Parametrised in data width, depth, read latency and burst mode; supports single and burst reads and writes.
//  Write bursts use per-byte enables and honour write-protect; WAIT throttles the host during read latency.
//  Sits between the host GPMC pins (via the top-level IO buffers) and the FPGA-side register/buffer space.
// PARAMETERS
//  DATA_W    16  bus/word width in bits; must be a multiple of 8; NBE = DATA_W/8
//  ADDR_W    10  word-address width; DEPTH = 2**ADDR_W words
//  RD_LAT    2   cycles from first post-address edge to first read word valid; legal range 1..7
//  BURST_LEN 0   0 = linear, wraps at DEPTH; 4/8/16 = wrap within an aligned BURST_LEN-word block
// PORTS
//  GPMC_CLK      in   1       bus clock, all logic on the rising edge
//  RST_N         in   1       asynchronous, active-low reset
//  GPMC_AD_IN    in   DATA_W  muxed address/data from host
//  GPMC_DATA_OUT out  DATA_W  read data to IO buffer
//  GPMC_DATA_OE  out  1       1 = drive the AD pins with GPMC_DATA_OUT
//  GPMC_CS       in   1       chip select, active-low
//  GPMC_ADV      in   1       address valid, active-low
//  GPMC_OE       in   1       output enable (read), active-low
//  GPMC_WE       in   1       write enable, active-low
//  GPMC_DIR      in   1       1 = host input (slave may drive), 0 = host output
//  GPMC_BE_N     in   NBE     byte enables, active-low; bit i covers bits [8i+7:8i]
//  GPMC_WP       in   1       write protect, active-low (0 = writes blocked)
//  GPMC_WAIT     out  1       1 = not ready (read latency in progress)
// BEHAVIOUR
//  Reset (async on RST_N low): state IDLE; DATA_OUT=0, DATA_OE=0, WAIT=0; address and beat counters 0.
//   RAM contents are not reset.
//  State IDLE: on an edge with CS=0 and ADV=0, latch addr=AD_IN[ADDR_W-1:0] -> ADDR.
//  State ADDR: re-latch the address on every edge while ADV=0.
//   The first edge with ADV=1 is E0.
//   At E0, if WE=0 -> WRITE and beat 0 is captured at E0; else if OE=0 -> RLAT with WAIT=1.
//   If neither is asserted, stay in ADDR until WE=0 or OE=0.
//  State WRITE: at each edge E0+k with WE=0, write AD_IN to RAM[addr_k] for every byte with BE_N[i]=0.
//   The write is suppressed entirely when WP=0.
//   addr_k advances after each beat; an edge with WE=1 and CS=0 holds the address (host stall).
//  State RLAT: WAIT=1 after edges E0..E0+RD_LAT-2, counting latency.
//   At edge E0+RD_LAT-1 -> RBURST and WAIT=0 after that edge.
//  State RBURST: word k is on DATA_OUT after edge E0+RD_LAT+k-1 and held one cycle.
//   DATA_OE=1 while CS=0, OE=0 and DIR=1.
//   Reads are registered from RAM with the next address prefetched so a beat is available every cycle.
//   The burst continues while OE=0.
//  Address sequence: addr_k = addr_0+k mod DEPTH (linear).
//   In wrap mode, low log2(BURST_LEN) bits increment mod BURST_LEN and upper bits are fixed.
//  Termination: an edge sampling CS=1 -> IDLE; DATA_OE=0 and WAIT=0 after that edge.
//   This applies in any state, including mid-latency and mid-burst; DATA_OUT holds its last value.
//   A new ADV=0 with CS=0 in WRITE or RBURST aborts the burst and re-enters ADDR.
//  Simultaneous WE=0 and OE=0 at E0: write wins.
//  RST_N asserted mid-burst: immediate return to reset values; no partial write after reset release.
// TESTING
//  1 Reset mid read burst (RST_N=0 between edges) -> DATA_OE=0, WAIT=0, DATA_OUT=0 before the next edge.
//  2 Write 16'hA5C3 @0x004 (BE_N=00, WP=1); read @0x004 with RD_LAT=2:
//    WAIT=1 for one cycle after E0, then DATA_OUT=16'hA5C3 with DATA_OE=1 after edge E0+1.
//  3 Write 16'h1234 @0x004 with BE_N=2'b10 -> read returns 16'hA534.
//  4 Linear 4-beat write @0x3FE of data 1,2,3,4 (DEPTH=1024) -> reads 0x3FE=1, 0x3FF=2, 0x000=3, 0x001=4.
//  5 BURST_LEN=4 instance, 4-beat read from 0x006 after loading RAM[i]=i -> DATA_OUT sequence 6,7,4,5.
//  6 Write 16'hFFFF @0x004 with WP=0 -> RAM unchanged (reads 16'hA534).
//    CS=1 in the third read beat -> DATA_OE=0 after that edge; state returns to IDLE.

Source files
------------

// File: rtl/gpmc_burst_sram_if.sv
// GPMC multiplexed address/data bus bundle between host pins and the burst SRAM slave.
interface gpmc_burst_sram_if #(
    parameter int DATA_W = 16
);
    localparam int NBE = DATA_W / 8;

    logic [DATA_W-1:0] gpmc_ad_in;     // muxed address/data from host
    logic [DATA_W-1:0] gpmc_data_out;  // read data towards the IO buffer
    logic              gpmc_data_oe;   // 1 = drive AD pins with gpmc_data_out
    logic              gpmc_cs;        // chip select, active-low
    logic              gpmc_adv;       // address valid, active-low
    logic              gpmc_oe;        // output enable, active-low
    logic              gpmc_we;        // write enable, active-low
    logic              gpmc_dir;       // 1 = host input, slave may drive
    logic [NBE-1:0]    gpmc_be_n;      // byte enables, active-low
    logic              gpmc_wp;        // write protect, active-low
    logic              gpmc_wait;      // 1 = not ready (read latency)

    modport master (
        output gpmc_ad_in, gpmc_cs, gpmc_adv, gpmc_oe, gpmc_we, gpmc_dir, gpmc_be_n, gpmc_wp,
        input  gpmc_data_out, gpmc_data_oe, gpmc_wait
    );

    modport slave (
        input  gpmc_ad_in, gpmc_cs, gpmc_adv, gpmc_oe, gpmc_we, gpmc_dir, gpmc_be_n, gpmc_wp,
        output gpmc_data_out, gpmc_data_oe, gpmc_wait
    );
endinterface

// File: rtl/gpmc_burst_sram.sv
// Synchronous GPMC slave on the multiplexed AD bus backed by a DEPTH-word RAM.
// Single/burst reads with programmable latency and WAIT, byte-enabled write
// bursts gated by write-protect, linear or aligned-wrap address sequencing.
module gpmc_burst_sram #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 2,
    parameter int BURST_LEN = 0
) (
    input  logic                  gpmc_clk,
    input  logic                  rst_n,
    gpmc_burst_sram_if.slave      bus
);
    localparam int NBE   = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    // Last latency count before the first read word is loaded.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    // Bits of the address that advance during a burst; upper bits stay fixed.
    localparam logic [ADDR_W-1:0] WRAP_MASK =
        (BURST_LEN == 0) ? {ADDR_W{1'b1}} : ADDR_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RLAT   = 3'd3,
        ST_RBURST = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [2:0]        lat_r, lat_nxt_s;
    logic [DATA_W-1:0] data_out_r;
    logic              data_oe_r, data_oe_nxt_s;
    logic              wait_r, wait_nxt_s;
    logic              mem_we_s;
    logic              rd_load_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Burst address successor: increments only the bits inside the wrap window.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] inc;
        inc = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        return (a & ~WRAP_MASK) | (inc & WRAP_MASK);
    endfunction

    // State, address, latency counter and registered bus outputs.
    always_ff @(posedge gpmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            lat_r      <= 3'd0;
            data_out_r <= '0;
            data_oe_r  <= 1'b0;
            wait_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
            lat_r     <= lat_nxt_s;
            data_oe_r <= data_oe_nxt_s;
            wait_r    <= wait_nxt_s;
            if (rd_load_s) begin
                data_out_r <= mem_r[addr_r];
            end
        end
    end

    // Next-state decode: bus phase tracking, beat strobes and address stepping.
    always_comb begin
        state_nxt_s   = state_r;
        addr_nxt_s    = addr_r;
        lat_nxt_s     = lat_r;
        data_oe_nxt_s = 1'b0;
        wait_nxt_s    = 1'b0;
        mem_we_s      = 1'b0;
        rd_load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!bus.gpmc_cs && !bus.gpmc_adv) begin
                    state_nxt_s = ST_ADDR;
                    addr_nxt_s  = bus.gpmc_ad_in[ADDR_W-1:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.gpmc_cs) begin
                    state_nxt_s = ST_IDLE;
                end else if (!bus.gpmc_adv) begin
                    addr_nxt_s = bus.gpmc_ad_in[ADDR_W-1:0];
                end else if (!bus.gpmc_we) begin
                    // Write wins over a simultaneous OE; beat 0 is taken at E0.
                    state_nxt_s = ST_WRITE;
                    mem_we_s    = bus.gpmc_wp;
                    addr_nxt_s  = next_addr(addr_r);
                end else if (!bus.gpmc_oe) begin
                    if (RD_LAT == 1) begin
                        state_nxt_s   = ST_RBURST;
                        rd_load_s     = 1'b1;
                        addr_nxt_s    = next_addr(addr_r);
                        data_oe_nxt_s = bus.gpmc_dir;
                    end else begin
                        state_nxt_s = ST_RLAT;
                        lat_nxt_s   = 3'd1;
                        wait_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_WRITE: begin
                if (bus.gpmc_cs) begin
                    state_nxt_s = ST_IDLE;
                end else if (!bus.gpmc_adv) begin
                    state_nxt_s = ST_ADDR;
                    addr_nxt_s  = bus.gpmc_ad_in[ADDR_W-1:0];
                end else if (!bus.gpmc_we) begin
                    mem_we_s   = bus.gpmc_wp;
                    addr_nxt_s = next_addr(addr_r);
                end else begin
                    // Host stall: hold the beat address.
                    addr_nxt_s = addr_r;
                end
            end
            ST_RLAT: begin
                if (bus.gpmc_cs) begin
                    state_nxt_s = ST_IDLE;
                    lat_nxt_s   = 3'd0;
                end else if (!bus.gpmc_adv) begin
                    state_nxt_s = ST_ADDR;
                    addr_nxt_s  = bus.gpmc_ad_in[ADDR_W-1:0];
                    lat_nxt_s   = 3'd0;
                end else if (lat_r == LAT_LAST) begin
                    state_nxt_s   = ST_RBURST;
                    rd_load_s     = 1'b1;
                    addr_nxt_s    = next_addr(addr_r);
                    lat_nxt_s     = 3'd0;
                    data_oe_nxt_s = !bus.gpmc_oe && bus.gpmc_dir;
                end else begin
                    lat_nxt_s  = lat_r + 3'd1;
                    wait_nxt_s = 1'b1;
                end
            end
            ST_RBURST: begin
                if (bus.gpmc_cs) begin
                    state_nxt_s = ST_IDLE;
                end else if (!bus.gpmc_adv) begin
                    state_nxt_s = ST_ADDR;
                    addr_nxt_s  = bus.gpmc_ad_in[ADDR_W-1:0];
                end else if (!bus.gpmc_oe) begin
                    rd_load_s     = 1'b1;
                    addr_nxt_s    = next_addr(addr_r);
                    data_oe_nxt_s = bus.gpmc_dir;
                end else begin
                    // Host paused the burst: keep address, release the pins.
                    addr_nxt_s = addr_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // RAM write port with per-byte enables; contents are deliberately not reset.
    always_ff @(posedge gpmc_clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NBE; i++) begin
                if (!bus.gpmc_be_n[i]) begin
                    mem_r[addr_r][8*i +: 8] <= bus.gpmc_ad_in[8*i +: 8];
                end
            end
        end
    end

    assign bus.gpmc_data_out = data_out_r;
    assign bus.gpmc_data_oe  = data_oe_r;
    assign bus.gpmc_wait     = wait_r;
endmodule

// File: tb/tb_gpmc_burst_sram.sv
// Directed bench for gpmc_burst_sram: a linear instance and a BURST_LEN=4 wrap
// instance share one host stimulus; each beat is checked against hand-computed values.
module tb_gpmc_burst_sram;
    logic        clk;
    logic        rst_n;
    logic [15:0] ad;
    logic        cs, adv, oe, we, dir, wp;
    logic [1:0]  be_n;
    int          n_tests;
    int          n_fail;

    gpmc_burst_sram_if #(.DATA_W(16)) bus_lin ();
    gpmc_burst_sram_if #(.DATA_W(16)) bus_wrp ();

    assign bus_lin.gpmc_ad_in = ad;
    assign bus_lin.gpmc_cs    = cs;
    assign bus_lin.gpmc_adv   = adv;
    assign bus_lin.gpmc_oe    = oe;
    assign bus_lin.gpmc_we    = we;
    assign bus_lin.gpmc_dir   = dir;
    assign bus_lin.gpmc_be_n  = be_n;
    assign bus_lin.gpmc_wp    = wp;

    assign bus_wrp.gpmc_ad_in = ad;
    assign bus_wrp.gpmc_cs    = cs;
    assign bus_wrp.gpmc_adv   = adv;
    assign bus_wrp.gpmc_oe    = oe;
    assign bus_wrp.gpmc_we    = we;
    assign bus_wrp.gpmc_dir   = dir;
    assign bus_wrp.gpmc_be_n  = be_n;
    assign bus_wrp.gpmc_wp    = wp;

    gpmc_burst_sram #(.DATA_W(16), .ADDR_W(10), .RD_LAT(2), .BURST_LEN(0)) u_lin (
        .gpmc_clk (clk),
        .rst_n    (rst_n),
        .bus      (bus_lin)
    );

    gpmc_burst_sram #(.DATA_W(16), .ADDR_W(10), .RD_LAT(2), .BURST_LEN(4)) u_wrp (
        .gpmc_clk (clk),
        .rst_n    (rst_n),
        .bus      (bus_wrp)
    );

    // 100 MHz bus clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_idle();
        cs = 1'b1; adv = 1'b1; oe = 1'b1; we = 1'b1; dir = 1'b0;
        be_n = 2'b11; wp = 1'b1; ad = 16'h0000;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3, input int n,
                            input logic [1:0] be, input logic wpv);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        cs = 1'b0; adv = 1'b0; ad = addr;
        step();
        adv = 1'b1; we = 1'b0; be_n = be; wp = wpv; ad = d[0];
        step();
        for (int k = 1; k < n; k++) begin
            ad = d[k];
            step();
        end
        we = 1'b1; cs = 1'b1;
        step();
        bus_idle();
    endtask

    // Address phase then E0 with OE asserted; returns just after E0.
    task automatic rd_begin(input logic [15:0] addr);
        cs = 1'b0; adv = 1'b0; ad = addr;
        step();
        adv = 1'b1; oe = 1'b0; dir = 1'b1; ad = 16'h0000;
        step();
    endtask

    task automatic rd_end();
        cs = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic rd_single(input logic [15:0] addr, input string tag, input logic [15:0] exp_v);
        rd_begin(addr);
        step();
        chk(tag, bus_lin.gpmc_data_out, exp_v);
        rd_end();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus_idle();
        rst_n = 1'b0;
        #12;
        chk("rst_data_out", bus_lin.gpmc_data_out, 16'h0000);
        chk("rst_data_oe",  {15'd0, bus_lin.gpmc_data_oe}, 16'h0000);
        chk("rst_wait",     {15'd0, bus_lin.gpmc_wait}, 16'h0000);
        #2 rst_n = 1'b1;
        step();

        // Single write then latency-2 read of the same word.
        do_write(16'h0004, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00, 1'b1);
        rd_begin(16'h0004);
        chk("t2_wait_e0",  {15'd0, bus_lin.gpmc_wait}, 16'h0001);
        chk("t2_oe_e0",    {15'd0, bus_lin.gpmc_data_oe}, 16'h0000);
        step();
        chk("t2_wait_e1",  {15'd0, bus_lin.gpmc_wait}, 16'h0000);
        chk("t2_oe_e1",    {15'd0, bus_lin.gpmc_data_oe}, 16'h0001);
        chk("t2_data",     bus_lin.gpmc_data_out, 16'hA5C3);

        // Asynchronous reset between edges in the middle of the read burst.
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_oe",   {15'd0, bus_lin.gpmc_data_oe}, 16'h0000);
        chk("t1_rst_wait", {15'd0, bus_lin.gpmc_wait}, 16'h0000);
        chk("t1_rst_data", bus_lin.gpmc_data_out, 16'h0000);
        bus_idle();
        #1 rst_n = 1'b1;
        step();

        // Upper byte disabled: only the low byte changes.
        do_write(16'h0004, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 2'b10, 1'b1);
        rd_single(16'h0004, "t3_be_merge", 16'hA534);

        // Write-protected write leaves RAM alone; CS high in beat 3 ends the burst.
        do_write(16'h0004, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00, 1'b0);
        rd_begin(16'h0004);
        step();
        chk("t6_wp_data",  bus_lin.gpmc_data_out, 16'hA534);
        chk("t6_oe_b0",    {15'd0, bus_lin.gpmc_data_oe}, 16'h0001);
        step();
        chk("t6_oe_b1",    {15'd0, bus_lin.gpmc_data_oe}, 16'h0001);
        cs = 1'b1;
        step();
        chk("t6_cs_oe",    {15'd0, bus_lin.gpmc_data_oe}, 16'h0000);
        chk("t6_cs_wait",  {15'd0, bus_lin.gpmc_wait}, 16'h0000);
        // Back in IDLE: CS low without ADV must not restart data drive.
        cs = 1'b0; adv = 1'b1; oe = 1'b0; dir = 1'b1;
        step();
        step();
        chk("t6_idle_oe",  {15'd0, bus_lin.gpmc_data_oe}, 16'h0000);
        chk("t6_idle_wait", {15'd0, bus_lin.gpmc_wait}, 16'h0000);
        bus_idle();
        step();

        // Linear burst write crossing the top of the address space.
        do_write(16'h03FE, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4, 2'b00, 1'b1);
        rd_single(16'h03FE, "t4_3fe", 16'h0001);
        rd_single(16'h03FF, "t4_3ff", 16'h0002);
        rd_single(16'h0000, "t4_000", 16'h0003);
        rd_single(16'h0001, "t4_001", 16'h0004);

        // Load RAM[4..7]=4..7 and burst-read from 6 on both instances.
        do_write(16'h0004, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 4, 2'b00, 1'b1);
        rd_begin(16'h0006);
        step();
        chk("t5_wrap_b0", bus_wrp.gpmc_data_out, 16'h0006);
        chk("t5_lin_b0",  bus_lin.gpmc_data_out, 16'h0006);
        step();
        chk("t5_wrap_b1", bus_wrp.gpmc_data_out, 16'h0007);
        chk("t5_lin_b1",  bus_lin.gpmc_data_out, 16'h0007);
        step();
        chk("t5_wrap_b2", bus_wrp.gpmc_data_out, 16'h0004);
        step();
        chk("t5_wrap_b3", bus_wrp.gpmc_data_out, 16'h0005);
        rd_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
